// File: rtl/fe_readout_serializer_if.sv
// fe_readout_serializer_if: FIFO read port and host byte-read handshake
interface fe_readout_serializer_if;
  logic [17:0] I_fifo_dout;
  logic        I_fifo_empty;
  logic        O_fifo_rd;
  logic        I_rd_strobe;
  logic [7:0]  O_rd_data;
  logic        O_data_valid;
  modport master (
    output I_fifo_dout, I_fifo_empty, I_rd_strobe,
    input  O_fifo_rd, O_rd_data, O_data_valid
  );
  modport slave (
    input  I_fifo_dout, I_fifo_empty, I_rd_strobe,
    output O_fifo_rd, O_rd_data, O_data_valid
  );
endinterface

// File: rtl/fe_readout_serializer.sv
// fe_readout_serializer: pulls 18-bit FIFO entries and presents them to the host as status, MSB, LSB bytes
module fe_readout_serializer #(
  parameter int pCOUNT_WIDTH = 16
) (
  input  logic                    cwusb_clk,
  input  logic                    reset_n,
  fe_readout_serializer_if.slave  bus,
  input  logic                    I_fifo_overflow_blocked,
  input  logic                    I_capture_done,
  input  logic                    I_flush,
  output logic [pCOUNT_WIDTH-1:0] O_entry_count
);
  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_VALID} state_t;
  state_t      state;
  logic [17:0] hold;
  logic [1:0]  idx;
  logic        sticky;
  logic        valid;
  logic        last;
  logic [7:0]  byte0;
  // Read enable is decided combinationally so the FIFO data lands exactly while in S_WAIT
  always_comb begin
    valid          = state == S_VALID;
    last           = valid && bus.I_rd_strobe && idx == 2'd2;
    byte0          = {sticky, I_capture_done, !valid, 3'b000, valid ? hold[17:16] : 2'b00};
    bus.O_rd_data  = !valid ? byte0 : idx == 2'd1 ? hold[15:8] : idx == 2'd2 ? hold[7:0] : byte0;
    bus.O_data_valid = valid;
    bus.O_fifo_rd  = !I_flush && !bus.I_fifo_empty && (state == S_EMPTY || last);
  end
  // Readout FSM, hold register, saturating entry counter and sticky overflow
  always_ff @(posedge cwusb_clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_EMPTY;
      idx           <= 2'd0;
      hold          <= 18'd0;
      sticky        <= 1'b0;
      O_entry_count <= '0;
    end else begin
      sticky <= I_flush ? 1'b0 : (sticky | I_fifo_overflow_blocked);
      if (I_flush) begin
        state         <= S_EMPTY;
        idx           <= 2'd0;
        hold          <= 18'd0;
        O_entry_count <= '0;
      end else begin
        case (state)
          S_EMPTY: if (bus.O_fifo_rd) state <= S_WAIT;
          S_WAIT: begin
            hold  <= bus.I_fifo_dout;
            idx   <= 2'd0;
            state <= S_VALID;
          end
          default: if (bus.I_rd_strobe) begin
            if (idx != 2'd2) idx <= idx + 2'd1;
            else begin
              state         <= bus.O_fifo_rd ? S_WAIT : S_EMPTY;
              O_entry_count <= (&O_entry_count) ? O_entry_count
                             : O_entry_count + {{(pCOUNT_WIDTH-1){1'b0}}, 1'b1};
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fe_readout_serializer.sv
// tb_fe_readout_serializer: directed checks of the readout serializer against a simple FIFO model
module tb_fe_readout_serializer;
  logic        cwusb_clk;
  logic        reset_n;
  logic        ovf;
  logic        cap_done;
  logic        flush;
  logic [15:0] cnt;
  logic [1:0]  cnt2;
  logic [17:0] mem [64];
  int          wp, rp, rd_pulses, flush_rds, checks, failures;
  fe_readout_serializer_if bus ();
  fe_readout_serializer_if bus2 ();
  fe_readout_serializer #(.pCOUNT_WIDTH(16)) dut (
    .cwusb_clk(cwusb_clk), .reset_n(reset_n), .bus(bus.slave),
    .I_fifo_overflow_blocked(ovf), .I_capture_done(cap_done), .I_flush(flush),
    .O_entry_count(cnt)
  );
  fe_readout_serializer #(.pCOUNT_WIDTH(2)) dut_sat (
    .cwusb_clk(cwusb_clk), .reset_n(reset_n), .bus(bus2.slave),
    .I_fifo_overflow_blocked(ovf), .I_capture_done(cap_done), .I_flush(flush),
    .O_entry_count(cnt2)
  );
  assign bus.I_fifo_empty  = wp == rp;
  assign bus2.I_fifo_dout  = bus.I_fifo_dout;
  assign bus2.I_fifo_empty = bus.I_fifo_empty;
  assign bus2.I_rd_strobe  = bus.I_rd_strobe;
  initial cwusb_clk = 1'b0;
  always #5 cwusb_clk = ~cwusb_clk;
  initial begin
    rp = 0;
    bus.I_fifo_dout = 18'd0;
  end
  // FIFO model: standard read port, data valid the cycle after the read enable
  always @(posedge cwusb_clk) begin
    if (bus.O_fifo_rd) begin
      bus.I_fifo_dout <= mem[rp];
      rp <= rp + 1;
      rd_pulses <= rd_pulses + 1;
      if (flush) flush_rds <= flush_rds + 1;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [17:0] v);
    mem[wp] = v;
    wp++;
  endtask
  task automatic rd_byte(input string tag, input logic [7:0] exp, input int gap);
    check(tag, bus.O_rd_data, exp);
    bus.I_rd_strobe = 1'b1;
    @(negedge cwusb_clk);
    bus.I_rd_strobe = 1'b0;
    repeat (gap - 1) @(negedge cwusb_clk);
  endtask
  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && !bus.O_data_valid; i++) @(negedge cwusb_clk);
    check(tag, bus.O_data_valid, 1);
  endtask
  initial begin
    int p0;
    checks = 0; failures = 0; wp = 0; rd_pulses = 0; flush_rds = 0;
    reset_n = 1'b0; ovf = 1'b0; cap_done = 1'b0; flush = 1'b0; bus.I_rd_strobe = 1'b0;
    repeat (2) @(negedge cwusb_clk);
    check("rst_data", bus.O_rd_data, 8'h20);
    check("rst_valid", bus.O_data_valid, 0);
    check("rst_cnt", cnt, 0);
    check("rst_rd", bus.O_fifo_rd, 0);
    cap_done = 1'b1;
    #1 check("rst_data_cap", bus.O_rd_data, 8'h60);
    cap_done = 1'b0;
    @(negedge cwusb_clk);
    reset_n = 1'b1;
    @(negedge cwusb_clk);
    push(18'h2_ABCD);
    #1 check("lat_rd", bus.O_fifo_rd, 1);
    @(negedge cwusb_clk);
    check("lat_wait", bus.O_data_valid, 0);
    check("lat_wait_rd", bus.O_fifo_rd, 0);
    @(negedge cwusb_clk);
    check("lat_valid", bus.O_data_valid, 1);
    rd_byte("single_b0", 8'h02, 4);
    rd_byte("single_b1", 8'hAB, 4);
    rd_byte("single_b2", 8'hCD, 4);
    check("single_cnt", cnt, 1);
    check("single_after", bus.O_rd_data, 8'h20);
    check("single_valid", bus.O_data_valid, 0);
    flush = 1'b1;
    @(negedge cwusb_clk);
    flush = 1'b0;
    check("flush_cnt", cnt, 0);
    p0 = rd_pulses;
    for (int i = 0; i < 4; i++) push({2'(i), 16'(i)});
    wait_valid("burst_valid");
    for (int i = 0; i < 4; i++) begin
      rd_byte("burst_b0", 8'(i), 3);
      rd_byte("burst_b1", 8'h00, 3);
      rd_byte("burst_b2", 8'(i), 3);
    end
    check("burst_pulses", rd_pulses - p0, 4);
    check("burst_cnt", cnt, 4);
    check("sat_cnt_4", cnt2, 3);
    p0 = rd_pulses;
    rd_byte("empty_strobe", 8'h20, 3);
    check("empty_pulses", rd_pulses - p0, 0);
    check("empty_cnt", cnt, 4);
    push(18'h1_0102);
    wait_valid("e2_valid");
    rd_byte("e2_b0", 8'h01, 3);
    rd_byte("e2_b1", 8'h01, 3);
    rd_byte("e2_b2", 8'h02, 3);
    check("e2_cnt", cnt, 5);
    check("sat_cnt_5", cnt2, 3);
    ovf = 1'b1;
    @(negedge cwusb_clk);
    ovf = 1'b0;
    check("ovf_idle", bus.O_rd_data, 8'hA0);
    push(18'h3_1234);
    push(18'h0_5678);
    wait_valid("ovf_valid");
    rd_byte("ovf_a0", 8'h83, 3);
    rd_byte("ovf_a1", 8'h12, 3);
    rd_byte("ovf_a2", 8'h34, 3);
    rd_byte("ovf_b0", 8'h80, 3);
    rd_byte("ovf_b1", 8'h56, 3);
    rd_byte("ovf_b2", 8'h78, 3);
    ovf = 1'b1;
    flush = 1'b1;
    @(negedge cwusb_clk);
    ovf = 1'b0;
    flush = 1'b0;
    check("ovf_flush", bus.O_rd_data, 8'h20);
    check("ovf_flush_cnt", cnt, 0);
    push(18'h1_AAAA);
    wait_valid("mid_valid");
    rd_byte("mid_b0", 8'h01, 3);
    rd_byte("mid_b1", 8'hAA, 3);
    push(18'h2_BBBB);
    flush = 1'b1;
    bus.I_rd_strobe = 1'b1;
    repeat (3) @(negedge cwusb_clk);
    bus.I_rd_strobe = 1'b0;
    check("mid_fl_valid", bus.O_data_valid, 0);
    check("mid_fl_cnt", cnt, 0);
    check("mid_fl_data", bus.O_rd_data, 8'h20);
    flush = 1'b0;
    wait_valid("mid_re_valid");
    check("mid_no_rd", flush_rds, 0);
    rd_byte("mid_r0", 8'h02, 3);
    rd_byte("mid_r1", 8'hBB, 3);
    rd_byte("mid_r2", 8'hBB, 3);
    check("mid_cnt", cnt, 1);
    ovf = 1'b1;
    @(negedge cwusb_clk);
    ovf = 1'b0;
    push(18'h3_CDEF);
    wait_valid("ar_valid");
    rd_byte("ar_b0", 8'h83, 3);
    check("ar_b1", bus.O_rd_data, 8'hCD);
    #2 reset_n = 1'b0;
    #1 check("ar_data", bus.O_rd_data, 8'h20);
    check("ar_valid", bus.O_data_valid, 0);
    check("ar_cnt", cnt, 0);
    check("ar_rd", bus.O_fifo_rd, 0);
    @(negedge cwusb_clk);
    reset_n = 1'b1;
    @(negedge cwusb_clk);
    check("ar_idle", bus.O_rd_data, 8'h20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
